// File: rtl/conv2d_stream.sv
// Streaming 3x3 convolution: two line buffers feed a 3x3 window, followed by a
// registered multiply stage and a registered sum/ReLU stage (2-cycle latency).
module conv2d_stream #(
    parameter int unsigned IMG_WIDTH  = 5,
    parameter int unsigned IMG_HEIGHT = 5,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned COEF_W     = 8,
    parameter int unsigned ACC_W      = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_W-1:0]             pixel_in,
    input  logic                          pixel_valid,
    input  logic                          coef_wr_en,
    input  logic [3:0]                    coef_addr,
    input  logic signed [COEF_W-1:0]      coef_data,
    input  logic                          cfg_stride2,
    input  logic                          cfg_relu,
    output logic signed [ACC_W-1:0]       conv_out,
    output logic                          valid,
    output logic [$clog2(IMG_HEIGHT)-1:0] out_row,
    output logic [$clog2(IMG_WIDTH)-1:0]  out_col,
    output logic                          frame_done
);

    localparam int unsigned ROW_W       = $clog2(IMG_HEIGHT);
    localparam int unsigned COL_W       = $clog2(IMG_WIDTH);
    localparam int unsigned PROD_W      = DATA_W + COEF_W + 1;
    localparam int unsigned NTAPS       = 9;
    localparam int unsigned LAST_ROW_S1 = IMG_HEIGHT - 3;
    localparam int unsigned LAST_COL_S1 = IMG_WIDTH - 3;
    localparam int unsigned LAST_ROW_S2 = ((IMG_HEIGHT - 3) / 2) * 2;
    localparam int unsigned LAST_COL_S2 = ((IMG_WIDTH - 3) / 2) * 2;

    logic [ROW_W-1:0]  row_cnt;
    logic [COL_W-1:0]  col_cnt;
    logic              cfg_stride2_q;
    logic              cfg_relu_q;

    logic              frame_start_c;
    logic              col_last_c;
    logic              row_last_c;
    logic              aligned_c;
    logic              win_done_c;
    logic              win_last_c;
    logic [ROW_W-1:0]  win_row_c;
    logic [COL_W-1:0]  win_col_c;

    logic [DATA_W-1:0] line1 [IMG_WIDTH];
    logic [DATA_W-1:0] line2 [IMG_WIDTH];
    logic [DATA_W-1:0] win   [NTAPS];

    logic signed [COEF_W-1:0] weight [NTAPS];
    logic                     coef_pend;
    logic [3:0]               coef_pend_addr;
    logic signed [COEF_W-1:0] coef_pend_data;

    logic              s0_valid;
    logic              s0_last;
    logic              s0_relu;
    logic [ROW_W-1:0]  s0_row;
    logic [COL_W-1:0]  s0_col;

    logic signed [PROD_W-1:0] prod_c [NTAPS];
    logic signed [PROD_W-1:0] prod_q [NTAPS];
    logic              s1_valid;
    logic              s1_last;
    logic              s1_relu;
    logic [ROW_W-1:0]  s1_row;
    logic [COL_W-1:0]  s1_col;

    logic signed [ACC_W-1:0] sum_c;
    logic signed [ACC_W-1:0] result_c;

    // Raster position of the pixel currently presented and window gating
    always_comb begin
        frame_start_c = (row_cnt == '0) && (col_cnt == '0);
        col_last_c    = (col_cnt == COL_W'(IMG_WIDTH - 1));
        row_last_c    = (row_cnt == ROW_W'(IMG_HEIGHT - 1));
        win_row_c     = row_cnt - ROW_W'(2);
        win_col_c     = col_cnt - COL_W'(2);
        aligned_c     = !cfg_stride2_q || (!row_cnt[0] && !col_cnt[0]);
        win_done_c    = pixel_valid && (row_cnt >= ROW_W'(2)) &&
                        (col_cnt >= COL_W'(2)) && aligned_c;
        if (cfg_stride2_q) begin
            win_last_c = (win_row_c == ROW_W'(LAST_ROW_S2)) &&
                         (win_col_c == COL_W'(LAST_COL_S2));
        end else begin
            win_last_c = (win_row_c == ROW_W'(LAST_ROW_S1)) &&
                         (win_col_c == COL_W'(LAST_COL_S1));
        end
    end

    // Position counters; frame config is sampled with the first pixel
    always_ff @(posedge clk) begin
        if (!rst) begin
            row_cnt       <= '0;
            col_cnt       <= '0;
            cfg_stride2_q <= 1'b0;
            cfg_relu_q    <= 1'b0;
        end else if (pixel_valid) begin
            if (frame_start_c) begin
                cfg_stride2_q <= cfg_stride2;
                cfg_relu_q    <= cfg_relu;
            end
            if (col_last_c) begin
                col_cnt <= '0;
                row_cnt <= row_last_c ? '0 : row_cnt + ROW_W'(1);
            end else begin
                col_cnt <= col_cnt + COL_W'(1);
            end
        end
    end

    // Line buffers and window; contents are don't-care until gated in
    always_ff @(posedge clk) begin
        if (rst && pixel_valid) begin
            line1[0] <= pixel_in;
            line2[0] <= line1[IMG_WIDTH-1];
            for (int unsigned i = 1; i < IMG_WIDTH; i++) begin
                line1[i] <= line1[i-1];
                line2[i] <= line2[i-1];
            end
            win[0] <= win[1];
            win[1] <= win[2];
            win[2] <= line2[IMG_WIDTH-1];
            win[3] <= win[4];
            win[4] <= win[5];
            win[5] <= line1[IMG_WIDTH-1];
            win[6] <= win[7];
            win[7] <= win[8];
            win[8] <= pixel_in;
        end
    end

    // Writes land one edge late so a window completing on the write edge keeps old weights
    always_ff @(posedge clk) begin
        if (!rst) begin
            coef_pend      <= 1'b0;
            coef_pend_addr <= '0;
            coef_pend_data <= '0;
            for (int unsigned i = 0; i < NTAPS; i++) begin
                weight[i] <= '0;
            end
        end else begin
            coef_pend      <= coef_wr_en && (coef_addr < 4'd9);
            coef_pend_addr <= coef_addr;
            coef_pend_data <= coef_data;
            if (coef_pend) begin
                weight[coef_pend_addr] <= coef_pend_data;
            end
        end
    end

    // Stage 0 control: window just completed
    always_ff @(posedge clk) begin
        if (!rst) begin
            s0_valid <= 1'b0;
            s0_last  <= 1'b0;
            s0_relu  <= 1'b0;
            s0_row   <= '0;
            s0_col   <= '0;
        end else begin
            s0_valid <= win_done_c;
            if (win_done_c) begin
                s0_last <= win_last_c;
                s0_relu <= cfg_relu_q;
                s0_row  <= win_row_c;
                s0_col  <= win_col_c;
            end
        end
    end

    // Unsigned pixel times signed weight
    always_comb begin
        for (int unsigned i = 0; i < NTAPS; i++) begin
            prod_c[i] = PROD_W'($signed({1'b0, win[i]})) * PROD_W'(weight[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (s0_valid) begin
            for (int unsigned i = 0; i < NTAPS; i++) begin
                prod_q[i] <= prod_c[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_relu  <= 1'b0;
            s1_row   <= '0;
            s1_col   <= '0;
        end else begin
            s1_valid <= s0_valid;
            if (s0_valid) begin
                s1_last <= s0_last;
                s1_relu <= s0_relu;
                s1_row  <= s0_row;
                s1_col  <= s0_col;
            end
        end
    end

    // Wrap-around sum of sign-extended products, then optional ReLU
    always_comb begin
        sum_c = '0;
        for (int unsigned i = 0; i < NTAPS; i++) begin
            sum_c = sum_c + ACC_W'(prod_q[i]);
        end
        result_c = (s1_relu && sum_c[ACC_W-1]) ? '0 : sum_c;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid      <= 1'b0;
            frame_done <= 1'b0;
            conv_out   <= '0;
            out_row    <= '0;
            out_col    <= '0;
        end else begin
            valid      <= s1_valid;
            frame_done <= s1_valid && s1_last;
            if (s1_valid) begin
                conv_out <= result_c;
                out_row  <= s1_row;
                out_col  <= s1_col;
            end
        end
    end

endmodule

// File: tb/tb_conv2d_stream.sv
// Directed bench for conv2d_stream on a 5x5 image with hand-computed results.
module tb_conv2d_stream;

    logic               clk;
    logic               rst;
    logic [7:0]         pixel_in;
    logic               pixel_valid;
    logic               coef_wr_en;
    logic [3:0]         coef_addr;
    logic signed [7:0]  coef_data;
    logic               cfg_stride2;
    logic               cfg_relu;
    logic signed [31:0] conv_out;
    logic               valid;
    logic [2:0]         out_row;
    logic [2:0]         out_col;
    logic               frame_done;

    int     n_checks = 0;
    int     n_fail   = 0;
    longint cyc      = 0;
    longint acc12    = 0;

    int     q_val[$];
    int     q_row[$];
    int     q_col[$];
    int     q_fd[$];
    longint q_cyc[$];
    int     e_val[$];
    int     e_row[$];
    int     e_col[$];
    int     e_fd[$];

    conv2d_stream #(
        .IMG_WIDTH(5), .IMG_HEIGHT(5), .DATA_W(8), .COEF_W(8), .ACC_W(32)
    ) dut (
        .clk(clk), .rst(rst), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
        .coef_wr_en(coef_wr_en), .coef_addr(coef_addr), .coef_data(coef_data),
        .cfg_stride2(cfg_stride2), .cfg_relu(cfg_relu), .conv_out(conv_out),
        .valid(valid), .out_row(out_row), .out_col(out_col), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            q_val.push_back(int'(conv_out));
            q_row.push_back(int'(out_row));
            q_col.push_back(int'(out_col));
            q_fd.push_back(int'(frame_done));
            q_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reset with junk on every input to show it is ignored
    task automatic do_reset();
        rst         = 1'b0;
        pixel_valid = 1'b1;
        pixel_in    = 8'd99;
        coef_wr_en  = 1'b1;
        coef_addr   = 4'd4;
        coef_data   = 8'sd5;
        repeat (2) tick();
        rst         = 1'b1;
        pixel_valid = 1'b0;
        coef_wr_en  = 1'b0;
    endtask

    task automatic set_weights(input int w[9]);
        for (int i = 0; i < 9; i++) begin
            coef_wr_en = 1'b1;
            coef_addr  = 4'(i);
            coef_data  = 8'(w[i]);
            tick();
        end
        coef_wr_en = 1'b0;
    endtask

    // cval<0 feeds the 0..24 ramp, else a constant frame
    task automatic feed_frame(input int gap_pct, input int cval,
                              input int toggle_at, input int wr_at);
        for (int p = 0; p < 25; p++) begin
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                pixel_valid = 1'b0;
                pixel_in    = 8'hEE;
                tick();
            end
            pixel_in    = (cval < 0) ? 8'(p) : 8'(cval);
            pixel_valid = 1'b1;
            if (p == toggle_at) cfg_relu = ~cfg_relu;
            if (p == wr_at) begin
                coef_wr_en = 1'b1;
                coef_addr  = 4'd0;
                coef_data  = 8'sd100;
            end
            tick();
            coef_wr_en = 1'b0;
            if (p == 12) acc12 = cyc;
        end
        pixel_valid = 1'b0;
    endtask

    task automatic drain();
        repeat (4) tick();
    endtask

    task automatic expect_grid(input int v[9]);
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                e_val.push_back(v[3*r+c]);
                e_row.push_back(r);
                e_col.push_back(c);
                e_fd.push_back((r == 2 && c == 2) ? 1 : 0);
            end
        end
    endtask

    task automatic expect_one(input int v, input int r, input int c, input int fd);
        e_val.push_back(v);
        e_row.push_back(r);
        e_col.push_back(c);
        e_fd.push_back(fd);
    endtask

    task automatic compare_outputs(input string tag);
        check($sformatf("%s count", tag), q_val.size(), e_val.size());
        for (int i = 0; i < e_val.size(); i++) begin
            if (i < q_val.size()) begin
                check($sformatf("%s[%0d] value", tag, i), q_val[i], e_val[i]);
                check($sformatf("%s[%0d] row", tag, i), q_row[i], e_row[i]);
                check($sformatf("%s[%0d] col", tag, i), q_col[i], e_col[i]);
                check($sformatf("%s[%0d] frame_done", tag, i), q_fd[i], e_fd[i]);
            end
        end
        q_val.delete(); q_row.delete(); q_col.delete(); q_fd.delete(); q_cyc.delete();
        e_val.delete(); e_row.delete(); e_col.delete(); e_fd.delete();
    endtask

    initial begin
        int lat;
        cfg_stride2 = 1'b0;
        cfg_relu    = 1'b0;
        do_reset();
        check("reset valid", valid, 1'b0);
        check("reset frame_done", frame_done, 1'b0);
        check("reset conv_out", conv_out, 0);
        check("reset out_row", out_row, 0);
        check("reset out_col", out_col, 0);

        set_weights('{1, 1, 1, 1, 1, 1, 1, 1, 1});
        feed_frame(0, -1, -1, -1);
        drain();
        lat = (q_cyc.size() > 0) ? int'(q_cyc[0] - acc12) : -1;
        check("first output latency", lat, 2);
        expect_grid('{54, 63, 72, 99, 108, 117, 144, 153, 162});
        compare_outputs("ramp");

        set_weights('{-1, -1, -1, -1, 8, -1, -1, -1, -1});
        feed_frame(0, -1, -1, -1);
        drain();
        expect_grid('{0, 0, 0, 0, 0, 0, 0, 0, 0});
        compare_outputs("zero_sum");

        set_weights('{-1, -1, -1, -1, -1, -1, -1, -1, -1});
        feed_frame(0, -1, -1, -1);
        drain();
        expect_grid('{-54, -63, -72, -99, -108, -117, -144, -153, -162});
        compare_outputs("neg_no_relu");

        cfg_relu = 1'b1;
        feed_frame(0, -1, -1, -1);
        drain();
        expect_grid('{0, 0, 0, 0, 0, 0, 0, 0, 0});
        compare_outputs("neg_relu");
        cfg_relu = 1'b0;

        set_weights('{1, 1, 1, 1, 1, 1, 1, 1, 1});
        cfg_stride2 = 1'b1;
        feed_frame(0, -1, -1, -1);
        cfg_stride2 = 1'b0;
        drain();
        expect_one(54, 0, 0, 0);
        expect_one(72, 0, 2, 0);
        expect_one(144, 2, 0, 0);
        expect_one(162, 2, 2, 1);
        compare_outputs("stride2");

        feed_frame(30, -1, -1, -1);
        drain();
        expect_grid('{54, 63, 72, 99, 108, 117, 144, 153, 162});
        compare_outputs("gapped");

        // ReLU flipped mid-frame only takes effect on the following frame
        set_weights('{-1, -1, -1, -1, -1, -1, -1, -1, -1});
        cfg_relu = 1'b0;
        feed_frame(0, -1, 5, -1);
        feed_frame(0, -1, -1, -1);
        drain();
        cfg_relu = 1'b0;
        expect_grid('{-54, -63, -72, -99, -108, -117, -144, -153, -162});
        expect_grid('{0, 0, 0, 0, 0, 0, 0, 0, 0});
        compare_outputs("back_to_back");

        set_weights('{127, 127, 127, 127, 127, 127, 127, 127, 127});
        feed_frame(0, 255, -1, -1);
        drain();
        expect_grid('{291465, 291465, 291465, 291465, 291465, 291465, 291465, 291465, 291465});
        compare_outputs("max_pos");

        set_weights('{-128, -128, -128, -128, -128, -128, -128, -128, -128});
        feed_frame(0, 255, -1, -1);
        drain();
        expect_grid('{-293760, -293760, -293760, -293760, -293760,
                      -293760, -293760, -293760, -293760});
        compare_outputs("max_neg");

        // weight0 := 100 on the edge that completes the first window
        set_weights('{1, 1, 1, 1, 1, 1, 1, 1, 1});
        feed_frame(0, -1, -1, 12);
        drain();
        expect_grid('{54, 162, 270, 594, 702, 810, 1134, 1242, 1350});
        compare_outputs("same_edge_write");

        for (int p = 0; p < 13; p++) begin
            pixel_in    = 8'(p);
            pixel_valid = 1'b1;
            tick();
        end
        rst = 1'b0;
        tick();
        @(negedge clk);
        check("valid after reset edge", valid, 1'b0);
        pixel_valid = 1'b1;
        pixel_in    = 8'd77;
        coef_wr_en  = 1'b1;
        coef_addr   = 4'd4;
        coef_data   = 8'sd5;
        tick();
        rst         = 1'b1;
        pixel_valid = 1'b0;
        coef_wr_en  = 1'b0;
        drain();
        check("no stale output", q_val.size(), 0);
        check("conv_out after reset", conv_out, 0);

        feed_frame(0, -1, -1, -1);
        drain();
        expect_grid('{0, 0, 0, 0, 0, 0, 0, 0, 0});
        compare_outputs("weights_cleared");

        set_weights('{-3, 0, 0, 0, 2, 0, 0, 0, 0});
        coef_wr_en = 1'b1;
        coef_addr  = 4'd9;
        coef_data  = 8'sd50;
        tick();
        coef_wr_en = 1'b0;
        feed_frame(0, -1, -1, -1);
        drain();
        expect_grid('{12, 11, 10, 7, 6, 5, 2, 1, 0});
        compare_outputs("reload");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv2d_stream.md
# conv2d_stream

Streaming 3x3 2-D convolution engine, the parametrised successor to `conv2d`. It accepts one raster-order pixel per handshake and builds the 3x3 window internally from two line buffers and a 3x3 register window. The nine signed kernel weights are loadable at run time. Each output goes through a fixed 2-stage multiply/accumulate pipeline. On top of `conv2d` it adds input gaps, stride-2 mode, optional ReLU, output coordinates, a frame-done pulse and back-to-back frames.

## Interface
Parameters:
- `IMG_WIDTH`, 5: pixels per row; must be >= 3.
- `IMG_HEIGHT`, 5: rows per frame; must be >= 3.
- `DATA_W`, 8: unsigned pixel width.
- `COEF_W`, 8: signed weight width.
- `ACC_W`, 32: signed output width; must be >= DATA_W+COEF_W+5.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-low reset.
- `pixel_in` in DATA_W: unsigned pixel, raster order.
- `pixel_valid` in 1: `pixel_in` is accepted on every edge where this is high; there is no backpressure.
- `coef_wr_en` in 1: writes a kernel weight.
- `coef_addr` in 4: weight index 0..8, row-major; 0 = window top-left (oldest pixel).
- `coef_data` in COEF_W: signed weight value.
- `cfg_stride2` in 1: stride-2 mode enable.
- `cfg_relu` in 1: clamp negative results to 0.
- `conv_out` out ACC_W: signed convolution result.
- `valid` out 1: `conv_out`, `out_row` and `out_col` are valid this cycle.
- `out_row` out $clog2(IMG_HEIGHT): window top-left row.
- `out_col` out $clog2(IMG_WIDTH): window top-left column.
- `frame_done` out 1: one-cycle pulse coincident with the last output of a frame.

## Operation
- Column and row counters advance only on accepted pixels.
  - Column wraps at IMG_WIDTH-1, then the row increments.
  - After (IMG_HEIGHT-1, IMG_WIDTH-1) both counters return to (0,0); the next accepted pixel starts a new frame with no bubble.
- Line buffers: two IMG_WIDTH-deep shift buffers hold the previous two rows and shift only on acceptance. The window registers shift in lockstep.
- Window completion: an accepted pixel at (r,c) with r>=2 and c>=2 completes the window whose top-left is (r-2,c-2).
  - Windows that straddle a row boundary are never emitted, so no flush is needed between frames.
- Stride-2 mode: a completed window is emitted only if (r-2) and (c-2) are both even.
- Output counts per frame:
  - Stride 1: (IMG_HEIGHT-2)*(IMG_WIDTH-2).
  - Stride 2: ceil((IMG_HEIGHT-2)/2)*ceil((IMG_WIDTH-2)/2).
- Config latching: `cfg_stride2` and `cfg_relu` are captured when the pixel at (0,0) is accepted and held for the whole frame. Mid-frame changes are ignored.
- Weights:
  - `coef_wr_en` writes `coef_data` to weight[`coef_addr`] at the edge.
  - Addresses 9..15 are ignored.
  - A write on the same edge as the window-completing pixel does not affect that window; it uses the old weights.
  - Writes are allowed at any time.
- Arithmetic:
  - Each pixel is zero-extended to DATA_W+1 bits and multiplied by its signed weight.
  - The nine products are sign-extended to ACC_W and summed with no saturation.
  - ReLU, when latched on, replaces negative sums with 0.
- `frame_done` is asserted with the final emitted window of the frame: (H-3,W-3) in stride 1; the last even-aligned window in stride 2.

## Timing
- Fixed latency of 2 cycles.
  - Pixel accepted at edge k: products registered at edge k+1, sum, ReLU and coordinates registered at edge k+2.
  - `valid` is high for exactly the one cycle following edge k+2.
- Gaps in `pixel_valid` do not stall the pipeline; in-flight results still emerge on schedule.
- Peak throughput is one output per cycle.
- Reset (rst=0 at an edge) sets:
  - `valid`, `frame_done`, `conv_out`, `out_row`, `out_col` to 0.
  - Row and column counters to (0,0).
  - All weights to 0 and latched config to 0.
  - The pipeline valid bits to 0, discarding in-flight results.
- Line-buffer contents are not reset; window gating makes them don't-care.
- Reset mid-frame aborts the frame. The first pixel accepted after release is (0,0).
- Inputs are ignored while rst=0.

## Test plan
- **Ramp, stride 1:** 5x5 image 0..24, all weights 1, stride 1, ReLU off, continuous valid -> 9 outputs: 54, 63, 72, 99, 108, 117, 144, 153, 162.
  - Coordinates run (0,0) to (2,2).
  - The first `valid` appears 2 cycles after pixel 12 is accepted.
  - `frame_done` pulses with 162.
- **Zero-sum kernel and ReLU:**
  - Centre weight 8, others -1, same ramp -> all 9 outputs are 0.
  - All weights -1, ReLU off -> -54 .. -162.
  - All weights -1, ReLU on -> nine zeros.
- **Stride 2:** ramp, all weights 1, `cfg_stride2`=1 -> 4 outputs: 54 @(0,0), 72 @(0,2), 144 @(2,0), 162 @(2,2). `frame_done` pulses with 162.
- **Gapped input, back-to-back frames:**
  - Random `pixel_valid` deassertions (about 30%) -> identical values and coordinates as the ramp test.
  - Two back-to-back frames -> 18 outputs and two `frame_done` pulses.
  - Toggling `cfg_relu` mid-frame changes nothing until the next frame.
- **Reset and weight writes:**
  - Assert rst after 12 pixels -> `valid` is 0 the cycle after the reset edge and no stale output appears.
  - Reload weights, then feed a full frame -> exactly 9 correct outputs.
  - A write to `coef_addr`=9 is ignored.
